// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes MIPS field records (R, lw, sw, beq, j) and streams them into instruction memory
module instr_encoder_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              err,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W:0]   word_count
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t      state, state_n;
    logic        legal, accept, commit, rewind, last_q;
    logic [31:0] enc;
    assign legal  = in_kind <= 3'd4;
    assign accept = in_valid & in_ready;
    assign commit = imem_we & imem_ready;
    assign rewind = done & clear;
    always_comb begin
        enc = in_kind == 3'd0 ? {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct} :
              in_kind == 3'd1 ? {6'b100011, in_rs, in_rt, in_imm} :
              in_kind == 3'd2 ? {6'b101011, in_rs, in_rt, in_imm} :
              in_kind == 3'd3 ? {6'b000100, in_rs, in_rt, in_imm} :
                                {6'b000010, in_target};
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        imem_we  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = legal ? WRITE : (in_last ? DONE : IDLE);
            end
            WRITE: begin
                imem_we = 1'b1;
                if (imem_ready) state_n = last_q ? DONE : IDLE;
            end
            DONE: begin
                done = 1'b1;
                if (clear) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // word register, counters and flags; commit and rewind never coincide (WRITE vs DONE)
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_addr  <= ADDR_W'(BASE_ADDR);
            imem_wdata <= '0;
            last_q     <= 1'b0;
            err        <= 1'b0;
            wrapped    <= 1'b0;
            word_count <= '0;
        end else begin
            err <= accept & ~legal;
            if (accept & legal) begin
                imem_wdata <= enc;
                last_q     <= in_last;
            end
            if (commit) begin
                imem_addr  <= imem_addr + 1'b1;
                word_count <= &word_count ? word_count : word_count + 1'b1;
                if (&imem_addr) wrapped <= 1'b1;
            end
            if (rewind) begin
                imem_addr  <= ADDR_W'(BASE_ADDR);
                word_count <= '0;
                wrapped    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: runs 8-bit and 2-bit address instances in lockstep against a write-count model
module tb_instr_encoder_loader;
    logic clk = 0, reset = 1, clear = 0, in_valid = 0, in_last = 0, imem_ready = 1;
    logic [2:0] in_kind = 0;
    logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
    logic [5:0] in_funct = 0;
    logic [15:0] in_imm = 0;
    logic [25:0] in_target = 0;
    logic in_ready8, in_ready2, we8, we2, err8, err2, done8, done2, wrap8, wrap2;
    logic [7:0] addr8;
    logic [1:0] addr2;
    logic [31:0] wdata8, wdata2;
    logic [8:0] cnt8;
    logic [2:0] cnt2;
    int checks = 0, fails = 0, n = 0;
    always #5 clk = ~clk;
    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8), .imem_ready(imem_ready),
        .err(err8), .done(done8), .wrapped(wrap8), .word_count(cnt8));
    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2), .imem_ready(imem_ready),
        .err(err2), .done(done2), .wrapped(wrap2), .word_count(cnt2));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] model_enc(input int unsigned k, rs, rt, rd, sh, fn, imm, tg);
        logic [31:0] regs;
        regs = (rs << 21) | (rt << 16);
        case (k)
            0: return regs | (rd << 11) | (sh << 6) | fn;
            1: return (32'd35 << 26) | regs | imm;
            2: return (32'd43 << 26) | regs | imm;
            3: return (32'd4 << 26) | regs | imm;
            default: return (32'd2 << 26) | tg;
        endcase
    endfunction
    task automatic status();
        chk("addr", {addr8, addr2}, {8'(n % 256), 2'(n % 4)});
        chk("count", {cnt8, cnt2}, {9'(n > 511 ? 511 : n), 3'(n > 7 ? 7 : n)});
        chk("wrapped", {wrap8, wrap2}, {n >= 256, n >= 4});
    endtask
    task automatic send(input int unsigned k, rs, rt, rd, sh, fn, imm, tg, input bit last, input int stalls);
        logic [31:0] e;
        e = model_enc(k, rs, rt, rd, sh, fn, imm, tg);
        in_valid = 1; in_kind = 3'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tg);
        in_last = last; imem_ready = stalls == 0;
        @(negedge clk);
        chk("ready", {in_ready8, in_ready2}, 2'b11);
        @(posedge clk); #1 in_valid = 0;
        if (k < 5) begin
            for (int i = 0; i <= stalls; i++) begin
                if (i == stalls) imem_ready = 1;
                @(negedge clk);
                chk("we", {we8, we2}, 2'b11);
                chk("waddr", {addr8, addr2}, {8'(n % 256), 2'(n % 4)});
                chk("wdata", {wdata8, wdata2}, {e, e});
                chk("busy", {in_ready8, in_ready2, done8, done2, err8, err2}, 0);
                @(posedge clk); #1;
            end
            n++;
        end else begin
            @(negedge clk);
            chk("err", {err8, err2, we8, we2}, 4'b1100);
            chk("err_done", {done8, done2, in_ready8, in_ready2}, {last, last, !last, !last});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("after", {err8, err2, we8, we2}, 0);
        chk("after_done", {done8, done2, in_ready8, in_ready2}, {last, last, !last, !last});
        status();
        @(posedge clk); #1;
    endtask
    task automatic pulse_clear(input bit in_done);
        clear = 1;
        @(posedge clk); #1 clear = 0;
        if (in_done) n = 0;
        @(negedge clk);
        chk("clr_ready", {in_ready8, in_ready2, done8, done2}, 4'b1100);
        status();
        @(posedge clk); #1;
    endtask
    task automatic send_rand(input int unsigned k, input bit last, input int stalls);
        send(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 63), $urandom_range(0, 65535), $urandom_range(0, 26'h3ffffff), last, stalls);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_ready", {in_ready8, in_ready2}, 2'b11);
        chk("rst_out", {we8, we2, err8, err2, done8, done2}, 0);
        chk("rst_wdata", {wdata8, wdata2}, 0);
        status();
        @(posedge clk); #1;
        send(0, 1, 2, 3, 0, 'h20, $urandom_range(0, 65535), $urandom_range(0, 1000), 0, 0);
        pulse_clear(0);
        send(1, 1, 2, 0, 0, 0, 4, 0, 0, 0);
        send(2, 1, 2, 0, 0, 0, 8, 0, 0, 0);
        send(3, 1, 2, 0, 0, 0, 'hffff, 0, 0, 0);
        send(4, 0, 0, 0, 0, 0, 0, 'h10, 1, 0);
        pulse_clear(1);
        send_rand(0, 0, 5);
        in_valid = 1; in_kind = 1; in_last = 0; imem_ready = 0;
        @(posedge clk); #1 in_valid = 0; reset = 1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        chk("rst_we", {we8, we2, in_ready8, in_ready2}, 4'b0011);
        chk("rst_wdata2", {wdata8, wdata2}, 0);
        status();
        @(posedge clk); #1 reset = 0; imem_ready = 1;
        send_rand(6, 0, 0);
        send(4, 0, 0, 0, 0, 0, 0, 'h123456, 1, 0);
        in_valid = 1; in_kind = 0;
        @(negedge clk);
        chk("done_hold", {we8, we2, in_ready8, in_ready2, done8, done2}, 6'b000011);
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk("done_ignore", {we8, we2, done8, done2}, 4'b0011);
        status();
        @(posedge clk); #1;
        pulse_clear(1);
        for (int i = 0; i < 5; i++) send_rand($urandom_range(0, 4), i == 4, 0);
        pulse_clear(1);
        for (int i = 0; i < 60; i++) begin
            int unsigned k;
            bit last;
            k = $urandom_range(0, 9) < 9 ? $urandom_range(0, 4) : $urandom_range(5, 7);
            last = $urandom_range(0, 11) == 0;
            send_rand(k, last, $urandom_range(0, 3));
            if (last) pulse_clear(1);
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
